// File: rtl/phase_pkg.sv
// Shared constants and FSM state type for the phase-measurement controller.
package phase_pkg;
  localparam int         PHASE_W   = 15;
  localparam logic [7:0] CMD_START = 8'h22;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    COLLECT,
    DIVIDE,
    VALID
  } state_t;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow asynchronous level signals.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // Two register stages to let a metastable first stage settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;
endmodule

// File: rtl/phase_meas_ctrl.sv
// Arms on a start command, averages 2**AVG_LOG2 phase samples taken on rising
// edges of the datapath Done, and hands the result over a valid/ready port.
module phase_meas_ctrl
  import phase_pkg::*;
#(
  parameter logic [7:0]  START_CODE  = CMD_START,
  parameter int          AVG_LOG2    = 3,
  parameter logic [23:0] TIMEOUT_CYC = 24'd10000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         cmd,
  input  logic               cmd_stb,
  input  logic               meas_done,
  input  logic [PHASE_W-1:0] meas_phase,
  input  logic               meas_sta,
  output logic [PHASE_W-1:0] res_phase,
  output logic               res_sta,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               busy,
  output logic               timeout
);
  localparam int N  = 1 << AVG_LOG2;
  localparam int AW = PHASE_W + AVG_LOG2;  // sum of N max samples fits exactly
  localparam int CW = AVG_LOG2 + 1;

  state_t             r_state, w_next;
  logic               r_done_q;
  logic [AW-1:0]      r_acc;
  logic [CW-1:0]      r_cnt;
  logic [23:0]        r_timer;
  logic [PHASE_W-1:0] r_res_phase;
  logic               r_res_sta;
  logic               r_timeout;
  logic               w_sta_sync;
  logic               w_start, w_evt, w_last, w_wait, w_tmo;

  sync_2ff #(.W(1)) u_sta_sync (
    .clk (clk),
    .rst (rst),
    .d   (meas_sta),
    .q   (w_sta_sync)
  );

  assign w_start = cmd_stb && (cmd == START_CODE);
  assign w_evt   = (r_state == COLLECT) && meas_done && !r_done_q;
  assign w_last  = w_evt && (r_cnt == CW'(N - 1));
  assign w_wait  = (r_state == FLUSH) || (r_state == COLLECT);
  // A sample landing in the expiry cycle wins over the timeout.
  assign w_tmo   = w_wait && !w_evt && (r_timer >= TIMEOUT_CYC - 24'd1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; start commands are only honoured in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = FLUSH;
      FLUSH:   if (w_tmo) w_next = IDLE;
               else if (!meas_done) w_next = COLLECT;
      COLLECT: if (w_last) w_next = DIVIDE;
               else if (w_tmo) w_next = IDLE;
      DIVIDE:  w_next = VALID;
      VALID:   if (res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs decoded from state plus the held result registers.
  always_comb begin
    busy      = (r_state != IDLE);
    res_valid = (r_state == VALID);
    res_phase = r_res_phase;
    res_sta   = r_res_sta;
    timeout   = r_timeout;
  end

  // Edge register, accumulator, sample counter, wait timer and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done_q    <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_timer     <= '0;
      r_res_phase <= '0;
      r_res_sta   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_done_q <= meas_done;
      if (r_state == IDLE && w_start) begin
        r_acc     <= '0;
        r_cnt     <= '0;
        r_timer   <= '0;
        r_timeout <= 1'b0;
      end else if (w_wait) begin
        if (w_evt) begin
          r_acc   <= r_acc + AW'(meas_phase);
          r_cnt   <= r_cnt + CW'(1);
          r_timer <= '0;
          if (w_last) r_res_sta <= w_sta_sync;
        end else if (w_tmo) begin
          r_timeout <= 1'b1;
        end else begin
          r_timer <= r_timer + 24'd1;
        end
      end else if (r_state == DIVIDE) begin
        r_res_phase <= r_acc[AVG_LOG2 +: PHASE_W];  // truncating divide by N
      end
    end
  end
endmodule

// File: tb/tb_phase_meas_ctrl.sv
// Directed bench for phase_meas_ctrl (AVG_LOG2=3, TIMEOUT_CYC=100).
module tb_phase_meas_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cmd = 8'h00;
  logic        cmd_stb = 1'b0;
  logic        meas_done = 1'b0;
  logic [14:0] meas_phase = '0;
  logic        meas_sta = 1'b1;
  logic [14:0] res_phase;
  logic        res_sta, res_valid, busy, timeout;
  logic        res_ready = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  phase_meas_ctrl #(
    .START_CODE  (8'h22),
    .AVG_LOG2    (3),
    .TIMEOUT_CYC (24'd100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd),
    .cmd_stb    (cmd_stb),
    .meas_done  (meas_done),
    .meas_phase (meas_phase),
    .meas_sta   (meas_sta),
    .res_phase  (res_phase),
    .res_sta    (res_sta),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .busy       (busy),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    @(negedge clk); cmd = c; cmd_stb = 1'b1;
    @(negedge clk); cmd_stb = 1'b0;
  endtask

  task automatic pulse(input logic [14:0] ph);
    @(negedge clk); meas_phase = ph; meas_done = 1'b1;
    repeat (2) @(negedge clk);
    meas_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic accept();
    @(negedge clk); res_ready = 1'b1;
    @(negedge clk); res_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // reset state
    chk("rst_phase", 32'(res_phase), 32'h0);
    chk("rst_sta",   32'(res_sta),   32'h0);
    chk("rst_valid", 32'(res_valid), 32'h0);
    chk("rst_busy",  32'(busy),      32'h0);
    chk("rst_tmo",   32'(timeout),   32'h0);

    // non-matching command is ignored
    send_cmd(8'h11);
    @(negedge clk);
    chk("bad_cmd_busy", 32'(busy), 32'h0);

    // nominal: phases 100..107 -> 103, res_valid two clocks after 8th rise
    send_cmd(8'h22);
    chk("nom_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 7; i++) pulse(15'(100 + i));
    @(negedge clk); meas_phase = 15'd107; meas_done = 1'b1;
    @(negedge clk);
    chk("nom_lat1", 32'(res_valid), 32'h0);
    @(negedge clk);
    chk("nom_lat2", 32'(res_valid), 32'h1);
    chk("nom_phase", 32'(res_phase), 32'd103);
    chk("nom_sta",   32'(res_sta),   32'h1);
    meas_done = 1'b0;
    // backpressure with stray commands
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 10) begin cmd = 8'h22; cmd_stb = 1'b1; end
      else if (i == 20) begin cmd = 8'h11; cmd_stb = 1'b1; end
      else cmd_stb = 1'b0;
    end
    chk("bp_valid", 32'(res_valid), 32'h1);
    chk("bp_phase", 32'(res_phase), 32'd103);
    accept();
    chk("acc_valid", 32'(res_valid), 32'h0);
    chk("acc_busy",  32'(busy),      32'h0);

    // stale Done high at start is discarded
    @(negedge clk); meas_phase = 15'd5000; meas_done = 1'b1;
    send_cmd(8'h22);
    repeat (4) @(negedge clk);
    meas_done = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) pulse(15'(200 + i));
    chk("stale_valid", 32'(res_valid), 32'h1);
    chk("stale_phase", 32'(res_phase), 32'd203);
    accept();

    // timeout: 3 samples then silence; expiry 100 clocks after last event
    send_cmd(8'h22);
    for (int i = 0; i < 2; i++) pulse(15'd50);
    @(negedge clk); meas_phase = 15'd50; meas_done = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 99; i++) begin
      @(posedge clk); #1;
      if (i == 3) meas_done = 1'b0;
    end
    chk("tmo_early", 32'(timeout), 32'h0);
    chk("tmo_busy0", 32'(busy),    32'h1);
    @(posedge clk); #1;
    chk("tmo_flag",  32'(timeout),   32'h1);
    chk("tmo_busy",  32'(busy),      32'h0);
    chk("tmo_valid", 32'(res_valid), 32'h0);

    // reset mid-COLLECT after 4 samples
    send_cmd(8'h22);
    chk("tmo_clr", 32'(timeout), 32'h0);
    for (int i = 0; i < 4; i++) pulse(15'd1000);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("mrst_busy",  32'(busy),      32'h0);
    chk("mrst_phase", 32'(res_phase), 32'h0);
    chk("mrst_valid", 32'(res_valid), 32'h0);
    send_cmd(8'h22);
    for (int i = 0; i < 7; i++) pulse(15'(300 + i));
    chk("mrst_7", 32'(res_valid), 32'h0);
    pulse(15'd307);
    chk("mrst_phase2", 32'(res_phase), 32'd303);
    accept();

    // max values, meas_sta low
    meas_sta = 1'b0;
    repeat (4) @(negedge clk);
    send_cmd(8'h22);
    for (int i = 0; i < 8; i++) pulse(15'h7FFF);
    chk("max_valid", 32'(res_valid), 32'h1);
    chk("max_phase", 32'(res_phase), 32'h7FFF);
    chk("max_sta",   32'(res_sta),   32'h0);
    accept();
    chk("max_idle", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
